ascon_aead_controller: RTL and testbench

//  Sequences one shared ASCON_PERMUTATION instance to perform ASCON-128 AEAD encrypt/decrypt (rate 64 b).

---
 rtl/ascon_aead_controller_if.sv | 42 ++++
 rtl/ascon_aead_controller.sv | 209 ++++++++++++++++++++
 tb/tb_ascon_aead_controller.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_aead_controller_if.sv
// ascon_aead_controller_if: groups the host-side data/tag handshake and the
// permutation-side launch/return signals of the ASCON-128 AEAD controller.
// slave  = controller view, master = host + permutation view.
interface ascon_aead_controller_if;
  logic         start;
  logic         decrypt;
  logic         has_ad;
  logic [127:0] key;
  logic [127:0] nonce;
  logic [127:0] tag_in;
  logic [63:0]  din;
  logic         din_last;
  logic         din_valid;
  logic         din_ready;
  logic [63:0]  dout;
  logic         dout_valid;
  logic [127:0] tag_out;
  logic         tag_valid;
  logic         tag_ok;
  logic         busy;
  logic [319:0] perm_state_in;
  logic [3:0]   perm_rounds;
  logic         perm_start;
  logic [319:0] perm_state_out;
  logic         perm_done;

  modport slave (
    input  start, decrypt, has_ad, key, nonce, tag_in,
    input  din, din_last, din_valid,
    output din_ready, dout, dout_valid, tag_out, tag_valid, tag_ok, busy,
    output perm_state_in, perm_rounds, perm_start,
    input  perm_state_out, perm_done
  );

  modport master (
    output start, decrypt, has_ad, key, nonce, tag_in,
    output din, din_last, din_valid,
    input  din_ready, dout, dout_valid, tag_out, tag_valid, tag_ok, busy,
    input  perm_state_in, perm_rounds, perm_start,
    output perm_state_out, perm_done
  );
endinterface

// File: rtl/ascon_aead_controller.sv
// ascon_aead_controller: sequences one shared ASCON permutation to run ASCON-128
//   AEAD encrypt/decrypt over full 64-bit blocks; owns the 320-bit state.
// Latency: start->perm_start 1 cycle; per data block 1 + perm latency + 1 cycles.
// Backpressure: din_ready only in AD_IN/MSG_IN, low while a permutation runs.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries start/key/
//   nonce/tag_in/din handshake, dout/tag outputs, busy, and the perm_* launch
//   (state_in, rounds, start) / return (state_out, done) pair.
module ascon_aead_controller #(
  parameter logic [63:0] IV       = 64'h80400C0600000000,
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 6
) (
  input logic                     clk,
  input logic                     rst_n,
  ascon_aead_controller_if.slave  bus
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_PERM_WAIT = 4'd1;
  localparam logic [3:0] S_INIT_KEY  = 4'd2;
  localparam logic [3:0] S_AD_IN     = 4'd3;
  localparam logic [3:0] S_AD_PAD    = 4'd4;
  localparam logic [3:0] S_DOMSEP    = 4'd5;
  localparam logic [3:0] S_MSG_IN    = 4'd6;
  localparam logic [3:0] S_MSG_PAD   = 4'd7;
  localparam logic [3:0] S_FINAL     = 4'd8;
  localparam logic [3:0] S_TAG       = 4'd9;

  localparam logic [63:0] PAD   = 64'h8000000000000000;
  localparam logic [3:0]  RND_A = 4'(ROUNDS_A);
  localparam logic [3:0]  RND_B = 4'(ROUNDS_B);

  logic [3:0]   fsm_q, fsm_d;
  logic [3:0]   ret_q, ret_d;         // state to resume after the running permutation
  logic [319:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic         dec_q, dec_d;
  logic         had_q, had_d;
  logic [3:0]   rounds_q, rounds_d;
  logic         perm_start_q, perm_start_d;
  logic [63:0]  dout_q, dout_d;
  logic         dout_valid_q, dout_valid_d;
  logic [127:0] tag_out_q, tag_out_d;
  logic         tag_valid_q, tag_valid_d;
  logic         tag_ok_q, tag_ok_d;
  logic         busy_q, busy_d;
  logic [127:0] tag_calc;
  logic         xfer;

  assign bus.din_ready     = (fsm_q == S_AD_IN) || (fsm_q == S_MSG_IN);
  assign xfer              = bus.din_valid && bus.din_ready;
  assign bus.dout          = dout_q;
  assign bus.dout_valid    = dout_valid_q;
  assign bus.tag_out       = tag_out_q;
  assign bus.tag_valid     = tag_valid_q;
  assign bus.tag_ok        = tag_ok_q;
  assign bus.busy          = busy_q;
  // state_q and rounds_q are frozen in PERM_WAIT, so the permutation inputs stay stable
  assign bus.perm_state_in = state_q;
  assign bus.perm_rounds   = rounds_q;
  assign bus.perm_start    = perm_start_q;

  always_comb begin
    fsm_d        = fsm_q;
    ret_d        = ret_q;
    state_d      = state_q;
    key_d        = key_q;
    dec_d        = dec_q;
    had_d        = had_q;
    rounds_d     = rounds_q;
    perm_start_d = 1'b0;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    tag_out_d    = tag_out_q;
    tag_valid_d  = 1'b0;
    tag_ok_d     = tag_ok_q;
    busy_d       = busy_q;
    tag_calc     = bus.perm_state_out[127:0] ^ key_q;

    case (fsm_q)
      S_IDLE: begin
        if (bus.start) begin
          key_d        = bus.key;
          dec_d        = bus.decrypt;
          had_d        = bus.has_ad;
          state_d      = {IV, bus.key, bus.nonce};
          rounds_d     = RND_A;
          perm_start_d = 1'b1;
          ret_d        = S_INIT_KEY;
          fsm_d        = S_PERM_WAIT;
          busy_d       = 1'b1;
        end
      end

      S_PERM_WAIT: begin
        if (bus.perm_done) begin
          state_d = bus.perm_state_out;
          fsm_d   = ret_q;
          // Tag is produced straight from the final permutation result so that
          // tag_valid lands in the TAG cycle while busy is still high.
          if (ret_q == S_TAG) begin
            tag_out_d   = tag_calc;
            tag_ok_d    = dec_q ? (tag_calc == bus.tag_in) : 1'b1;
            tag_valid_d = 1'b1;
          end
        end
      end

      S_INIT_KEY: begin
        state_d[127:0] = state_q[127:0] ^ key_q;
        fsm_d          = had_q ? S_AD_IN : S_DOMSEP;
      end

      S_AD_IN: begin
        if (xfer) begin
          state_d[319:256] = state_q[319:256] ^ bus.din;
          rounds_d         = RND_B;
          perm_start_d     = 1'b1;
          ret_d            = bus.din_last ? S_AD_PAD : S_AD_IN;
          fsm_d            = S_PERM_WAIT;
        end
      end

      S_AD_PAD: begin
        state_d[319:256] = state_q[319:256] ^ PAD;
        rounds_d         = RND_B;
        perm_start_d     = 1'b1;
        ret_d            = S_DOMSEP;
        fsm_d            = S_PERM_WAIT;
      end

      S_DOMSEP: begin
        state_d[0] = ~state_q[0];
        fsm_d      = S_MSG_IN;
      end

      S_MSG_IN: begin
        if (xfer) begin
          // Output is x0^B for both directions; decrypt replaces x0 by the ciphertext.
          dout_d           = state_q[319:256] ^ bus.din;
          dout_valid_d     = 1'b1;
          state_d[319:256] = dec_q ? bus.din : (state_q[319:256] ^ bus.din);
          rounds_d         = RND_B;
          perm_start_d     = 1'b1;
          ret_d            = bus.din_last ? S_MSG_PAD : S_MSG_IN;
          fsm_d            = S_PERM_WAIT;
        end
      end

      S_MSG_PAD: begin
        state_d[319:256] = state_q[319:256] ^ PAD;
        fsm_d            = S_FINAL;
      end

      S_FINAL: begin
        state_d[255:128] = state_q[255:128] ^ key_q;
        rounds_d         = RND_A;
        perm_start_d     = 1'b1;
        ret_d            = S_TAG;
        fsm_d            = S_PERM_WAIT;
      end

      S_TAG: begin
        busy_d = 1'b0;
        fsm_d  = S_IDLE;
      end

      default: begin
        fsm_d  = S_IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= S_IDLE;
      ret_q        <= S_IDLE;
      state_q      <= '0;
      key_q        <= '0;
      dec_q        <= 1'b0;
      had_q        <= 1'b0;
      rounds_q     <= '0;
      perm_start_q <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      tag_out_q    <= '0;
      tag_valid_q  <= 1'b0;
      tag_ok_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      ret_q        <= ret_d;
      state_q      <= state_d;
      key_q        <= key_d;
      dec_q        <= dec_d;
      had_q        <= had_d;
      rounds_q     <= rounds_d;
      perm_start_q <= perm_start_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      tag_out_q    <= tag_out_d;
      tag_valid_q  <= tag_valid_d;
      tag_ok_q     <= tag_ok_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_ascon_aead_controller.sv
// tb_ascon_aead_controller: drives ASCON-128 AEAD operations into the controller,
// acts as the permutation (behavioural ASCON-p with random latency) and compares
// outputs against an algorithm-level reference model.
module tb_ascon_aead_controller;

  localparam logic [63:0] IV  = 64'h80400C0600000000;
  localparam logic [63:0] PAD = 64'h8000000000000000;
  localparam int TMO = 300;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ascon_aead_controller_if ifc ();
  ascon_aead_controller dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_p(input logic [319:0] s, input int nr);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    for (int i = 12 - nr; i < 12; i++) begin
      x2 = x2 ^ 64'(((15 - i) << 4) | i);
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
      x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
      x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
      x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
      x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  // ---------------- permutation responder ----------------
  logic [319:0] rsp_state;
  logic [3:0]   rsp_rounds;
  bit           rsp_pend = 0;
  int           rsp_cnt = 0;
  int           stab_err = 0;
  logic [3:0]   rlog[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      rsp_pend = 0;
      ifc.perm_done = 1'b0;
    end else begin
      ifc.perm_done = 1'b0;
      if (rsp_pend) begin
        if (ifc.perm_state_in !== rsp_state || ifc.perm_rounds !== rsp_rounds || ifc.perm_start !== 1'b0)
          stab_err++;
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          ifc.perm_state_out = ascon_p(rsp_state, int'(rsp_rounds));
          ifc.perm_done = 1'b1;
          rsp_pend = 0;
        end
      end else if (ifc.perm_start) begin
        rsp_state  = ifc.perm_state_in;
        rsp_rounds = ifc.perm_rounds;
        rlog.push_back(ifc.perm_rounds);
        rsp_pend = 1;
        rsp_cnt  = $urandom_range(1, 4);
      end
    end
  end

  // ---------------- output monitor ----------------
  logic [63:0]  got_dout[$];
  int           tag_cnt = 0;
  logic [127:0] got_tag;
  logic         got_ok, got_busy;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.dout_valid) got_dout.push_back(ifc.dout);
      if (ifc.tag_valid) begin
        tag_cnt++;
        got_tag  = ifc.tag_out;
        got_ok   = ifc.tag_ok;
        got_busy = ifc.busy;
      end
    end
  end

  // ---------------- operation description + reference model ----------------
  bit           op_dec, op_had;
  logic [127:0] op_key, op_nonce, op_tagin;
  int           op_nad, op_nmsg;
  logic [63:0]  ad_w[8];
  logic [63:0]  msg_w[8];

  logic [63:0]  exp_dout[$];
  logic [3:0]   exp_r[$];
  logic [127:0] exp_tag;
  logic         exp_ok;
  int           last_perm_cnt;

  task automatic model();
    logic [319:0] s;
    logic [63:0] c;
    exp_dout.delete();
    exp_r.delete();
    s = {IV, op_key, op_nonce};
    s = ascon_p(s, 12); exp_r.push_back(4'd12);
    s[127:0] ^= op_key;
    if (op_had) begin
      for (int i = 0; i < op_nad; i++) begin
        s[319:256] ^= ad_w[i];
        s = ascon_p(s, 6); exp_r.push_back(4'd6);
      end
      s[319:256] ^= PAD;
      s = ascon_p(s, 6); exp_r.push_back(4'd6);
    end
    s[0] = ~s[0];
    for (int i = 0; i < op_nmsg; i++) begin
      c = s[319:256] ^ msg_w[i];
      exp_dout.push_back(c);
      s[319:256] = op_dec ? msg_w[i] : c;
      s = ascon_p(s, 6); exp_r.push_back(4'd6);
    end
    s[319:256] ^= PAD;
    s[255:128] ^= op_key;
    s = ascon_p(s, 12); exp_r.push_back(4'd12);
    exp_tag = s[127:0] ^ op_key;
    exp_ok  = op_dec ? (exp_tag == op_tagin) : 1'b1;
  endtask

  task automatic rand_op();
    op_dec   = 1'($urandom_range(0, 1));
    op_had   = 1'($urandom_range(0, 1));
    op_nad   = $urandom_range(1, 3);
    op_nmsg  = $urandom_range(1, 4);
    op_key   = {$urandom, $urandom, $urandom, $urandom};
    op_nonce = {$urandom, $urandom, $urandom, $urandom};
    op_tagin = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 8; i++) begin
      ad_w[i]  = {$urandom, $urandom};
      msg_w[i] = {$urandom, $urandom};
    end
  endtask

  task automatic feed_block(input logic [63:0] d, input bit last, input bit stall, input bit spam);
    bit done = 0;
    int guard = 0;
    ifc.din = d;
    ifc.din_last = last;
    while (!done && guard < TMO) begin
      ifc.din_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      ifc.start = spam && ($urandom_range(0, 5) == 0);
      done = ifc.din_valid && ifc.din_ready;
      @(negedge clk);
      guard++;
    end
    ifc.din_valid = 1'b0;
    ifc.start = 1'b0;
    if (!done) chk("din_accept_timeout", 0, 1);
  endtask

  task automatic launch();
    ifc.decrypt = op_dec;
    ifc.has_ad  = op_had;
    ifc.key     = op_key;
    ifc.nonce   = op_nonce;
    ifc.tag_in  = op_tagin;
    ifc.start   = 1'b1;
    @(negedge clk);
    ifc.start   = 1'b0;
  endtask

  task automatic run_op(input bit stall, input bit spam);
    int rb, db, tb0, sb, guard, n;
    model();
    rb = rlog.size(); db = got_dout.size(); tb0 = tag_cnt; sb = stab_err;
    launch();
    if (op_had)
      for (int i = 0; i < op_nad; i++) feed_block(ad_w[i], i == op_nad - 1, stall, spam);
    for (int i = 0; i < op_nmsg; i++) feed_block(msg_w[i], i == op_nmsg - 1, stall, spam);
    guard = 0;
    while (!ifc.tag_valid && guard < TMO) begin
      @(negedge clk);
      guard++;
    end
    chk("tag_valid_seen", ifc.tag_valid, 1);
    @(negedge clk);
    chk("busy_after_tag", ifc.busy, 0);
    chk("tag_valid_pulse", ifc.tag_valid, 0);
    chk("busy_at_tag", got_busy, 1);
    chk("tag_cnt", tag_cnt - tb0, 1);
    chk("tag", got_tag, exp_tag);
    chk("tag_ok", got_ok, exp_ok);
    last_perm_cnt = rlog.size() - rb;
    chk("perm_cnt", last_perm_cnt, exp_r.size());
    n = (last_perm_cnt < exp_r.size()) ? last_perm_cnt : exp_r.size();
    for (int i = 0; i < n; i++) chk("perm_rounds", rlog[rb + i], exp_r[i]);
    chk("dout_cnt", got_dout.size() - db, exp_dout.size());
    n = (got_dout.size() - db < exp_dout.size()) ? got_dout.size() - db : exp_dout.size();
    for (int i = 0; i < n; i++) chk("dout", got_dout[db + i], exp_dout[i]);
    chk("perm_inputs_stable", stab_err - sb, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [63:0]  p_word, c_word;
  logic [127:0] t_enc, tag_a;
  int dc, tc, rb0, guard;

  initial begin
    ifc.start = 0; ifc.decrypt = 0; ifc.has_ad = 0;
    ifc.key = '0; ifc.nonce = '0; ifc.tag_in = '0;
    ifc.din = '0; ifc.din_last = 0; ifc.din_valid = 0;
    ifc.perm_state_out = '0;

    // reset state
    #1;
    chk("rst_busy", ifc.busy, 0);
    chk("rst_din_ready", ifc.din_ready, 0);
    chk("rst_dout_valid", ifc.dout_valid, 0);
    chk("rst_tag_valid", ifc.tag_valid, 0);
    chk("rst_perm_start", ifc.perm_start, 0);
    chk("rst_perm_rounds", ifc.perm_rounds, 0);
    chk("rst_perm_state", ifc.perm_state_in, 0);
    chk("rst_tag_out", ifc.tag_out, 0);
    chk("rst_dout", ifc.dout, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // start->perm_start latency is one cycle
    rand_op();
    op_had = 0; op_nmsg = 1; op_dec = 0;
    rb0 = rlog.size();
    ifc.key = op_key; ifc.nonce = op_nonce; ifc.decrypt = 0; ifc.has_ad = 0;
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    chk("busy_after_start", ifc.busy, 1);
    chk("perm_start_lat1", ifc.perm_start, 1);
    chk("perm_rounds_init", ifc.perm_rounds, 12);
    @(negedge clk);
    feed_block(msg_w[0], 1'b1, 1'b0, 1'b0);
    guard = 0;
    while (ifc.busy && guard < TMO) begin @(negedge clk); guard++; end
    chk("lat_op_done", ifc.busy, 0);
    @(negedge clk);

    // 1: reset during message permutation wait
    rand_op();
    op_had = 0; op_nmsg = 2;
    rb0 = rlog.size();
    launch();
    feed_block(msg_w[0], 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (!((rlog.size() - rb0) == 2 && rsp_pend) && guard < TMO) begin @(negedge clk); guard++; end
    chk("reached_msg_perm", rlog.size() - rb0, 2);
    dc = got_dout.size(); tc = tag_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", ifc.busy, 0);
    chk("abort_perm_start", ifc.perm_start, 0);
    chk("abort_din_ready", ifc.din_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_tag", tag_cnt - tc, 0);
    chk("abort_no_dout", got_dout.size() - dc, 0);
    chk("abort_idle_busy", ifc.busy, 0);
    rand_op();
    run_op(1'b0, 1'b0);

    // 2: no AD, one message block
    rand_op();
    op_had = 0; op_nmsg = 1; op_dec = 0;
    run_op(1'b0, 1'b0);
    chk("t2_perm_cnt", last_perm_cnt, 3);

    // 3: two AD blocks, three message blocks
    rand_op();
    op_had = 1; op_nad = 2; op_nmsg = 3; op_dec = 0;
    run_op(1'b0, 1'b0);
    chk("t3_perm_cnt", last_perm_cnt, 8);

    // 4: K=N=0 round trip
    p_word = 64'h0011223344556677;
    op_dec = 0; op_had = 0; op_nmsg = 1; op_key = '0; op_nonce = '0; op_tagin = '0;
    msg_w[0] = p_word;
    run_op(1'b0, 1'b0);
    c_word = got_dout[got_dout.size() - 1];
    t_enc = got_tag;
    chk("t4_enc_ok", got_ok, 1);
    op_dec = 1; op_tagin = t_enc; msg_w[0] = c_word;
    run_op(1'b0, 1'b0);
    chk("t4_dec_plain", got_dout[got_dout.size() - 1], p_word);
    chk("t4_dec_tag_ok", got_ok, 1);

    // 5: corrupted tag, then corrupted ciphertext
    op_tagin = t_enc ^ 128'd1;
    run_op(1'b0, 1'b0);
    chk("t5_badtag_ok", got_ok, 0);
    op_tagin = t_enc; msg_w[0] = c_word ^ 64'd1;
    run_op(1'b0, 1'b0);
    chk("t5_badct_ok", got_ok, 0);

    // 6: random operations, stall-free then stalled with stray start pulses
    for (int k = 0; k < 5; k++) begin
      rand_op();
      run_op(1'b0, 1'b0);
      tag_a = got_tag;
      run_op(1'b1, 1'b1);
      chk("t6_stall_tag_match", got_tag, tag_a);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
